mem_arbiter: RTL

- Shares the single synchronous data RAM port between two requesters: requester 0 is the CPU load/store path, and requester 1 is a device master (DMA or video fetch).
- Each requester uses a req/ack handshake. The arbiter latches the winning request, drives the RAM for one access, waits the RAM read latency, then returns read data with a one-cycle ack.
- It sits between the CPU datapath memory interface and the RAM.

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Signal bundle between the two requesters, the shared RAM port and the arbiter.
// The arbiter binds the master modport; requesters, RAM and observers use slave.
interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dev_req;
  logic              dev_we;
  logic [ADDR_W-1:0] dev_addr;
  logic [DATA_W-1:0] dev_wdata;
  logic              dev_ack;
  logic [DATA_W-1:0] dev_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  logic [1:0]        owner;
  logic              busy;

  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_ack, cpu_rdata,
    input  dev_req, dev_we, dev_addr, dev_wdata,
    output dev_ack, dev_rdata,
    output mem_addr, mem_wdata, mem_write,
    input  mem_rdata,
    output owner, busy
  );

  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_ack, cpu_rdata,
    output dev_req, dev_we, dev_addr, dev_wdata,
    input  dev_ack, dev_rdata,
    input  mem_addr, mem_wdata, mem_write,
    output mem_rdata,
    input  owner, busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester arbiter for a single synchronous RAM port: one access in flight,
// round-robin or fixed priority, read data returned with a one-cycle ack.
module mem_arbiter #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int READ_LATENCY   = 1,
  parameter int FIXED_PRIORITY = 0
) (
  input logic           clock,
  input logic           reset,
  mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam logic [2:0] CNT_INIT = 3'(READ_LATENCY - 1);
  localparam logic       FIXED    = (FIXED_PRIORITY != 0);

  state_t            state_q, state_d;
  logic [1:0]        owner_q, owner_d;
  logic              last_grant_q, last_grant_d;  // 0 = cpu, 1 = dev
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] dev_rdata_q, dev_rdata_d;
  logic              win_dev;

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dev_rdata_d  = dev_rdata_q;

    // On a tie the device wins only in round-robin mode when the cpu went last
    win_dev = bus.dev_req & (~bus.cpu_req | (~FIXED & ~last_grant_q));

    case (state_q)
      IDLE: begin
        if (bus.cpu_req | bus.dev_req) begin
          state_d      = ISSUE;
          owner_d      = win_dev ? 2'b10 : 2'b01;
          last_grant_d = win_dev;
          we_d         = win_dev ? bus.dev_we    : bus.cpu_we;
          addr_d       = win_dev ? bus.dev_addr  : bus.cpu_addr;
          wdata_d      = win_dev ? bus.dev_wdata : bus.cpu_wdata;
        end
      end
      ISSUE: begin
        if (we_q) begin
          state_d = DONE;
        end else begin
          state_d = WAIT;
          cnt_d   = CNT_INIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = DONE;
          if (owner_q[1]) dev_rdata_d = bus.mem_rdata;
          else            cpu_rdata_d = bus.mem_rdata;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        owner_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      owner_q      <= 2'b00;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= 3'd0;
      cpu_rdata_q  <= '0;
      dev_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dev_rdata_q  <= dev_rdata_d;
    end
  end

  // Outputs decode straight from registers so an async reset clears them at once
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.mem_write = (state_q == ISSUE) & we_q;
  assign bus.cpu_ack   = (state_q == DONE) & owner_q[0];
  assign bus.dev_ack   = (state_q == DONE) & owner_q[1];
  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.dev_rdata = dev_rdata_q;
  assign bus.owner     = owner_q;
  assign bus.busy      = (state_q != IDLE);

endmodule
